regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//   Synchronous register file: 2^ADDR_WIDTH entries of DATA_WIDTH bits, one write
//   port and two independent read ports. Provides small multi-ported scratch
//   storage in datapaths.
//   Any address conflict between active ports is flagged on `collision`; the
//   conflicting cycle returns zero on both read outputs.
//   All outputs are registered.
// PARAMETERS
//   DATA_WIDTH  32  width of each register entry and of din/dout1/dout2
//   ADDR_WIDTH   5  address width; depth = 2**ADDR_WIDTH (32 entries by default)
// PORTS
//   clk        in   1           single clock; all state updates on rising edge
//   resetn     in   1           asynchronous, active-low reset
//   din        in   DATA_WIDTH  write data
//   wad1       in   ADDR_WIDTH  write address
//   wen1       in   1           write enable
//   rad1       in   ADDR_WIDTH  read address, port 1
//   ren1       in   1           read enable, port 1
//   rad2       in   ADDR_WIDTH  read address, port 2
//   ren2       in   1           read enable, port 2
//   dout1      out  DATA_WIDTH  registered read data, port 1
//   dout2      out  DATA_WIDTH  registered read data, port 2
//   collision  out  1           registered conflict flag
// BEHAVIOUR
// - Reset (resetn=0, async)
//   - Every storage entry, dout1, dout2 and collision go to 0 immediately.
//   - They stay 0 while resetn is low.
// - Collision detect (combinational on sampled inputs; result registered)
//   - c_rr = ren1 & ren2 & (rad1==rad2)
//   - c_w1 = wen1 & ren1 & (wad1==rad1)
//   - c_w2 = wen1 & ren2 & (wad1==rad2)
//   - col  = c_rr | c_w1 | c_w2; collision <= col at each rising edge.
// - Write
//   - On a rising edge with wen1=1: mem[wad1] <= din.
//   - The write is performed even when col=1.
// - Read: 1-cycle latency; outputs are updated at the same edge that samples the inputs.
//   - dout1 <= (ren1 & !col) ? mem[rad1] : 0, where mem is the pre-edge contents (no write-through).
//   - dout2 <= (ren2 & !col) ? mem[rad2] : 0
//   - A disabled port outputs 0 the cycle after its enable drops; no last-value hold.
//   - When col=1, both dout1 and dout2 are 0 for that cycle, including a port not
//     involved in the conflict.
// - Never-written entries read as 0.
// - Corner cases
//   - A write with both reads disabled: no collision.
//   - ren2=1 with ren1=0 at the same address: no collision.
//   - Reset asserted mid-operation clears contents; in-flight reads return 0.
// TESTING
// - Reset for 3 cycles; read any address -> dout1=dout2=0, collision=0.
// - Write 0xA5A5_0001 to addr 5 (wen1=1, one cycle), then ren1=1, rad1=5
//   -> dout1=0xA5A5_0001 one cycle later, collision=0.
// - ren1=1, rad1=10 (never written) -> dout1=0x0.
// - ren1=ren2=1, rad1=5, rad2=10 -> dout1=0xA5A5_0001, dout2=0, collision=0.
// - ren1=ren2=1, rad1=rad2=5 -> collision=1, dout1=dout2=0.
//   Deassert the enables -> collision=0 next cycle.
// - wen1=1, wad1=5, din=0x1234_5678, ren1=1, rad1=5 -> collision=1, dout1=0.
//   Then wen1=0, ren1=1, rad1=5 -> dout1=0x1234_5678, collision=0.

Source files
------------

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with one write port and two read ports.
// Any address conflict between active ports raises a registered collision
// flag and forces both read outputs to zero for that cycle. Reads return
// the contents from before the edge; a same-cycle write is not forwarded.

module regfile_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] wad1,
    input  logic                  wen1,
    input  logic [ADDR_WIDTH-1:0] rad1,
    input  logic                  ren1,
    input  logic [ADDR_WIDTH-1:0] rad2,
    input  logic                  ren2,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic [DATA_WIDTH-1:0] dout2,
    output logic                  collision
);

    localparam int Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    logic [DATA_WIDTH-1:0] dout1_q;
    logic [DATA_WIDTH-1:0] dout1_d;
    logic [DATA_WIDTH-1:0] dout2_q;
    logic [DATA_WIDTH-1:0] dout2_d;
    logic                  collision_q;
    logic                  collision_d;

    logic                  colReadRead;
    logic                  colWriteRead1;
    logic                  colWriteRead2;

    // Detect conflicts between active ports and select the next read data.
    always_comb begin
        colReadRead   = ren1 & ren2 & (rad1 == rad2);
        colWriteRead1 = wen1 & ren1 & (wad1 == rad1);
        colWriteRead2 = wen1 & ren2 & (wad1 == rad2);
        collision_d   = colReadRead | colWriteRead1 | colWriteRead2;

        dout1_d = '0;
        dout2_d = '0;
        if (ren1 && !collision_d) begin
            dout1_d = mem_q[rad1];
        end
        if (ren2 && !collision_d) begin
            dout2_d = mem_q[rad2];
        end
    end

    // Storage array; the write lands even when a collision is flagged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wen1) begin
            mem_q[wad1] <= din;
        end
    end

    // Registered read data and collision flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout1_q     <= '0;
            dout2_q     <= '0;
            collision_q <= 1'b0;
        end else begin
            dout1_q     <= dout1_d;
            dout2_q     <= dout2_d;
            collision_q <= collision_d;
        end
    end

    assign dout1     = dout1_q;
    assign dout2     = dout2_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed and randomised checks of regfile_2r1w using a
// behavioural memory model that feeds an expected-result queue.

module tb_regfile_2r1w;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 2 ** AW;

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic          col;
    } expect_t;

    logic          clk;
    logic          resetn;
    logic [DW-1:0] din;
    logic [AW-1:0] wad1;
    logic          wen1;
    logic [AW-1:0] rad1;
    logic          ren1;
    logic [AW-1:0] rad2;
    logic          ren2;
    logic [DW-1:0] dout1;
    logic [DW-1:0] dout2;
    logic          collision;

    logic [DW-1:0] model [DEPTH];
    expect_t       scoreboard [$];

    int assertCount = 0;
    int failCount   = 0;

    regfile_2r1w #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .din       (din),
        .wad1      (wad1),
        .wen1      (wen1),
        .rad1      (rad1),
        .ren1      (ren1),
        .rad2      (rad2),
        .ren2      (ren2),
        .dout1     (dout1),
        .dout2     (dout2),
        .collision (collision)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare all three outputs against fixed values.
    task automatic checkValues(input string tag, input logic [DW-1:0] e1,
                               input logic [DW-1:0] e2, input logic ec);
        assertCount++;
        assert (dout1 === e1) else begin
            failCount++;
            $error("[TB] FAIL %s dout1: observed %h expected %h", tag, dout1, e1);
        end
        assertCount++;
        assert (dout2 === e2) else begin
            failCount++;
            $error("[TB] FAIL %s dout2: observed %h expected %h", tag, dout2, e2);
        end
        assertCount++;
        assert (collision === ec) else begin
            failCount++;
            $error("[TB] FAIL %s collision: observed %b expected %b", tag, collision, ec);
        end
    endtask

    // Drive one cycle of inputs, predict the result from the model, then
    // advance past the edge and check the DUT against the queued prediction.
    task automatic applyStimulus(input string tag,
                                 input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic r1, input logic [AW-1:0] a1,
                                 input logic r2, input logic [AW-1:0] a2);
        expect_t e;
        logic    col;
        wen1 = we; wad1 = wa; din = wd;
        ren1 = r1; rad1 = a1;
        ren2 = r2; rad2 = a2;
        col = (r1 && r2 && a1 == a2) || (we && r1 && wa == a1) || (we && r2 && wa == a2);
        e.col = col;
        e.d1  = (r1 && !col) ? model[a1] : '0;
        e.d2  = (r2 && !col) ? model[a2] : '0;
        scoreboard.push_back(e);
        if (we) model[wa] = wd;
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Pop the oldest prediction and compare it with the DUT outputs.
    task automatic checkOutput(input string tag);
        expect_t e;
        if (scoreboard.size() == 0) begin
            assertCount++;
            failCount++;
            $error("[TB] FAIL %s scoreboard: observed empty expected entry", tag);
        end else begin
            e = scoreboard.pop_front();
            checkValues(tag, e.d1, e.d2, e.col);
        end
    endtask

    task automatic idleInputs();
        wen1 = 1'b0; wad1 = '0; din = '0;
        ren1 = 1'b0; rad1 = '0;
        ren2 = 1'b0; rad2 = '0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        idleInputs();

        // Reset for three cycles and check outputs are cleared.
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkValues("reset", '0, '0, 1'b0);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("read_after_reset", 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd17);
        applyStimulus("write_a5", 1'b1, 5'd5, 32'hA5A5_0001, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus("read_a5", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        applyStimulus("read_unwritten", 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0, 5'd0);
        applyStimulus("dual_read", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd10);
        applyStimulus("rr_collision", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
        applyStimulus("enables_dropped", 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b0, 5'd5);
        applyStimulus("wr1_collision", 1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd5, 1'b0, 5'd0);
        applyStimulus("read_after_wr1", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        applyStimulus("write_only", 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd7, 1'b0, 5'd7);
        applyStimulus("ren2_only_same_addr", 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 1'b1, 5'd7);
        applyStimulus("write_top", 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd5, 1'b1, 5'd7);
        applyStimulus("read_top", 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd0);
        applyStimulus("wr2_collision", 1'b1, 5'd7, 32'h0BAD_F00D, 1'b1, 5'd5, 1'b1, 5'd7);
        applyStimulus("read_after_wr2", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd7);

        // Randomised traffic over a narrow address range to provoke conflicts.
        for (int i = 0; i < 60; i++) begin
            applyStimulus("random", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
        end

        // Reset asserted mid-operation: outputs clear immediately, contents lost.
        wen1 = 1'b1; wad1 = 5'd9; din = 32'h5555_AAAA;
        ren1 = 1'b1; rad1 = 5'd5; ren2 = 1'b1; rad2 = 5'd31;
        #2 resetn = 1'b0;
        #1;
        checkValues("async_reset", '0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        scoreboard.delete();
        @(posedge clk);
        #1;
        checkValues("held_in_reset", '0, '0, 1'b0);
        #3 resetn = 1'b1;
        #2;
        applyStimulus("read_after_midreset", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31);
        applyStimulus("read_after_midreset2", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd7);
        idleInputs();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
